cordic_vec_collector: RTL

//  Sink stage after the last vector-mode CORDIC rotation stage. The stages carry no valid or stall,
//  so this block tracks accepted launches through a STAGES-deep valid delay line. It captures the

---
 rtl/cordic_pkg.sv | 12 +
 rtl/cordic_vec_collector_if.sv | 30 +++
 rtl/cordic_res_fifo.sv | 54 +++++
 rtl/cordic_vec_collector.sv | 115 +++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// Shared constants for the vector-mode CORDIC result collector.
// Gain, fixed-point format and default sizing.
package cordic_pkg;

  localparam int          DEF_DATA_W     = 32;
  localparam int          DEF_STAGES     = 16;
  localparam int          DEF_FIFO_DEPTH = 4;
  localparam int          GAIN_FRAC      = 30;
  localparam logic [31:0] DEF_GAIN_K     = 32'h26DD3B6A;
  localparam logic [31:0] MAG_MAX        = 32'h7FFFFFFF;

endpackage

// File: rtl/cordic_vec_collector_if.sv
// Launch/chain inputs and result valid/ready port of the collector.
// slave: collector side; master: launcher/consumer side.
interface cordic_vec_collector_if
  import cordic_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
);
  logic              launch_valid;
  logic              launch_ready;
  logic [DATA_W-1:0] chain_x;
  logic [DATA_W-1:0] chain_y;
  logic [DATA_W-1:0] chain_z;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_mag;
  logic [DATA_W-1:0] m_resid;
  logic [DATA_W-1:0] m_tag;

  modport slave (
    input  launch_valid, chain_x, chain_y, chain_z,
    input  m_ready,
    output launch_ready, m_valid, m_mag, m_resid, m_tag
  );

  modport master (
    output launch_valid, chain_x, chain_y, chain_z,
    output m_ready,
    input  launch_ready, m_valid, m_mag, m_resid, m_tag
  );
endinterface

// File: rtl/cordic_res_fifo.sv
// Show-ahead result FIFO; wr/rd strobes, head data, overflow pulse.
// Ports: clk, rst, wr_en_i/wr_data_i, rd_en_i, rd_valid_o/rd_data_o, ovf_o.
module cordic_res_fifo
  import cordic_pkg::*;
#(
  parameter int WIDTH = 3 * DEF_DATA_W,
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic             rd_valid_o,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             ovf_o
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wptr_q, wptr_d;
  logic [AW:0]      rptr_q, rptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             full, empty;
  logic             do_wr, do_rd;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) &&
                 (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

  // a read in the same cycle frees the slot a full write needs
  assign do_rd = rd_en_i & ~empty;
  assign do_wr = wr_en_i & (~full | do_rd);
  assign ovf_o = wr_en_i & full & ~do_rd;

  assign wptr_d = wptr_q + (AW+1)'(do_wr);
  assign rptr_d = rptr_q + (AW+1)'(do_rd);

  assign rd_valid_o = ~empty;
  assign rd_data_o  = mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wptr_q[AW-1:0]] <= wr_data_i;
  end
endmodule

// File: rtl/cordic_vec_collector.sv
// Sink after the last CORDIC stage: tracks launches, scales x by K, buffers.
// Ports: clk, RST, bus (launch/chain in, m_* result out), err (sticky).
module cordic_vec_collector
  import cordic_pkg::*;
#(
  parameter int                STAGES     = DEF_STAGES,
  parameter int                DATA_W     = DEF_DATA_W,
  parameter int                FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter logic [DATA_W-1:0] GAIN_K     = DEF_GAIN_K
) (
  input  logic                   clk,
  input  logic                   RST,
  cordic_vec_collector_if.slave  bus,
  output logic                   err
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = 2 * DATA_W;
  localparam int CW = 3 * DATA_W;

  localparam logic [DATA_W-1:0] MAX_N =
    {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [PW-1:0] MAX_W =
    {{DATA_W{1'b0}}, MAX_N};
  localparam logic signed [PW-1:0] HALF =
    {{(PW-1){1'b0}}, 1'b1} << (GAIN_FRAC - 1);

  logic              accept, pop;
  logic [AW:0]       outst_q, outst_d;
  logic [STAGES-1:0] dv_q;
  logic              cap;

  logic signed [PW-1:0] x_ext, k_ext, prod, scl;
  logic [DATA_W-1:0]    mag_d;

  logic              p_valid_q;
  logic [DATA_W-1:0] p_mag_q, p_resid_q, p_tag_q;
  logic              err_q, err_d;

  logic              f_valid, f_ovf;
  logic [CW-1:0]     f_head;

  assign bus.launch_ready =
    (outst_q < (AW+1)'(FIFO_DEPTH));
  assign accept = bus.launch_valid & bus.launch_ready;
  assign pop    = f_valid & bus.m_ready;
  assign cap    = dv_q[STAGES-1];

  always_comb begin
    x_ext = {{DATA_W{bus.chain_x[DATA_W-1]}}, bus.chain_x};
    k_ext = {{DATA_W{1'b0}}, GAIN_K};
    prod  = x_ext * k_ext;
    scl   = (prod + HALF) >>> GAIN_FRAC;
    mag_d = scl[DATA_W-1:0];
    if (bus.chain_x[DATA_W-1]) begin
      mag_d = '0;
    end else if (scl > MAX_W) begin
      mag_d = MAX_N;
    end
  end

  always_comb begin
    outst_d = outst_q;
    unique case ({accept, pop})
      2'b10:   outst_d = outst_q + (AW+1)'(1);
      2'b01:   outst_d = outst_q - (AW+1)'(1);
      default: outst_d = outst_q;
    endcase
  end

  assign err_d = err_q | f_ovf |
                 (cap & bus.chain_x[DATA_W-1]);

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      dv_q      <= '0;
      outst_q   <= '0;
      p_valid_q <= 1'b0;
      p_mag_q   <= '0;
      p_resid_q <= '0;
      p_tag_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      dv_q      <= STAGES'({dv_q, accept});
      outst_q   <= outst_d;
      p_valid_q <= cap;
      err_q     <= err_d;
      if (cap) begin
        p_mag_q   <= mag_d;
        p_resid_q <= bus.chain_y;
        p_tag_q   <= bus.chain_z;
      end
    end
  end

  cordic_res_fifo #(
    .WIDTH (CW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (RST),
    .wr_en_i    (p_valid_q),
    .wr_data_i  ({p_mag_q, p_resid_q, p_tag_q}),
    .rd_en_i    (pop),
    .rd_valid_o (f_valid),
    .rd_data_o  (f_head),
    .ovf_o      (f_ovf)
  );

  // empty FIFO shows zeros rather than a stale slot
  assign bus.m_valid = f_valid;
  assign bus.m_mag   = f_valid ? f_head[CW-1 -: DATA_W] : '0;
  assign bus.m_resid = f_valid ? f_head[PW-1 -: DATA_W] : '0;
  assign bus.m_tag   = f_valid ? f_head[DATA_W-1:0]     : '0;
  assign err         = err_q;
endmodule
